// File: rtl/tlb_search_unit_pkg.sv
// Shared definitions for the TLB search unit: sizes, packed entry layout,
// page-size codes, INVTLB op codes and the invalidation-walk state encoding.
package tlb_search_unit_pkg;

  localparam int TLBNUM  = 16;
  localparam int VPPN_W  = 19;
  localparam int ASID_W  = 10;
  localparam int PPN_W   = 20;
  localparam int PS_W    = 6;
  localparam int ENTRY_W = 89;

  localparam logic [PS_W-1:0] PS_4K = 6'd12;
  localparam logic [PS_W-1:0] PS_2M = 6'd21;

  // Field order matches the w_entry / r_entry packing, e in the MSB.
  typedef struct packed {
    logic              e;
    logic [VPPN_W-1:0] vppn;
    logic [PS_W-1:0]   ps;
    logic              g;
    logic [ASID_W-1:0] asid;
    logic [PPN_W-1:0]  ppn0;
    logic [1:0]        plv0;
    logic [1:0]        mat0;
    logic              d0;
    logic              v0;
    logic [PPN_W-1:0]  ppn1;
    logic [1:0]        plv1;
    logic [1:0]        mat1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  typedef enum logic [4:0] {
    INV_ALL0    = 5'd0,
    INV_ALL1    = 5'd1,
    INV_G1      = 5'd2,
    INV_G0      = 5'd3,
    INV_ASID    = 5'd4,
    INV_ASID_VA = 5'd5,
    INV_GA_VA   = 5'd6
  } inv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } inv_state_e;

endpackage

// File: rtl/tlb_entry_match.sv
// Per-entry compare: hit when valid, global-or-ASID match and the
// page-size-dependent VPPN tag matches the key.
module tlb_entry_match
  import tlb_search_unit_pkg::*;
(
  input  logic              e,
  input  logic              g,
  input  logic [PS_W-1:0]   ps,
  input  logic [VPPN_W-1:0] vppn,
  input  logic [ASID_W-1:0] asid,
  input  logic [VPPN_W-1:0] key_vppn,
  input  logic [ASID_W-1:0] key_asid,
  output logic              hit
);

  logic va_match;

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    va_match = 1'b0;
    if (ps == PS_4K)      va_match = (vppn == key_vppn);
    else if (ps == PS_2M) va_match = (vppn[18:9] == key_vppn[18:9]);
  end

  assign hit = e && (g || (asid == key_asid)) && va_match;

endmodule

// File: rtl/tlb_search_unit.sv
// TLB array with a registered single-port search, a registered read port,
// a write port, and a sequential INVTLB walk that clears one entry per cycle.
module tlb_search_unit
  import tlb_search_unit_pkg::*;
#(
  parameter int TLBNUM = tlb_search_unit_pkg::TLBNUM,
  parameter int IDXW   = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               s_req,
  input  logic [VPPN_W-1:0]  s_vppn,
  input  logic               s_va_bit12,
  input  logic [ASID_W-1:0]  s_asid,
  output logic               s_ack,
  output logic               s_found,
  output logic [IDXW-1:0]    s_index,
  output logic [PPN_W-1:0]   s_ppn,
  output logic [PS_W-1:0]    s_ps,
  output logic [1:0]         s_plv,
  output logic [1:0]         s_mat,
  output logic               s_d,
  output logic               s_v,
  input  logic               we,
  input  logic [IDXW-1:0]    w_index,
  input  logic [ENTRY_W-1:0] w_entry,
  input  logic [IDXW-1:0]    r_index,
  output logic [ENTRY_W-1:0] r_entry,
  input  logic               inv_req,
  input  logic [4:0]         inv_op,
  input  logic [ASID_W-1:0]  inv_asid,
  input  logic [VPPN_W-1:0]  inv_vppn,
  output logic               inv_busy,
  output logic               inv_done
);

  tlb_entry_t        entries [TLBNUM];
  logic [TLBNUM-1:0] s_hit;

  for (genvar i = 0; i < TLBNUM; i++) begin : g_match
    tlb_entry_match u_match (
      .e        (entries[i].e),
      .g        (entries[i].g),
      .ps       (entries[i].ps),
      .vppn     (entries[i].vppn),
      .asid     (entries[i].asid),
      .key_vppn (s_vppn),
      .key_asid (s_asid),
      .hit      (s_hit[i])
    );
  end

  logic            found;
  logic [IDXW-1:0] hit_idx;
  tlb_entry_t      hit_ent;
  logic            page1;

  // Scan from the top so the lowest hitting index is the last one written.
  always_comb begin
    found   = 1'b0;
    hit_idx = '0;
    hit_ent = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (s_hit[i]) begin
        found   = 1'b1;
        hit_idx = IDXW'(i);
        hit_ent = entries[i];
      end
    end
    page1 = (hit_ent.ps == PS_4K) ? s_va_bit12 : s_vppn[8];
  end

  // NOTE: sequential state is assigned with <= only, so every block sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_ack   <= 1'b0;
      s_found <= 1'b0;
      s_index <= '0;
      s_ppn   <= '0;
      s_ps    <= '0;
      s_plv   <= '0;
      s_mat   <= '0;
      s_d     <= 1'b0;
      s_v     <= 1'b0;
    end else begin
      s_ack <= s_req;
      if (s_req) begin
        s_found <= found;
        s_index <= hit_idx;
        s_ps    <= hit_ent.ps;
        s_ppn   <= page1 ? hit_ent.ppn1 : hit_ent.ppn0;
        s_plv   <= page1 ? hit_ent.plv1 : hit_ent.plv0;
        s_mat   <= page1 ? hit_ent.mat1 : hit_ent.mat0;
        s_d     <= page1 ? hit_ent.d1   : hit_ent.d0;
        s_v     <= page1 ? hit_ent.v1   : hit_ent.v0;
      end
    end
  end

  inv_state_e        state_q, state_d;
  logic [IDXW-1:0]   cnt_q, cnt_d;
  logic [4:0]        op_q;
  logic [ASID_W-1:0] asid_q;
  logic [VPPN_W-1:0] vppn_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      asid_q  <= '0;
      vppn_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && inv_req) begin
        op_q   <= inv_op;
        asid_q <= inv_asid;
        vppn_q <= inv_vppn;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (inv_req) begin
        state_d = ST_WALK;
        cnt_d   = '0;
      end
      ST_WALK: if (cnt_q == IDXW'(TLBNUM - 1)) begin
        state_d = ST_DONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign inv_busy = (state_q != ST_IDLE);
  assign inv_done = (state_q == ST_DONE);

  tlb_entry_t walk_ent;
  logic       walk_hit;
  logic       walk_asid_eq;
  logic       walk_clr;

  assign walk_ent = entries[cnt_q];

  tlb_entry_match u_walk_match (
    .e        (walk_ent.e),
    .g        (walk_ent.g),
    .ps       (walk_ent.ps),
    .vppn     (walk_ent.vppn),
    .asid     (walk_ent.asid),
    .key_vppn (vppn_q),
    .key_asid (asid_q),
    .hit      (walk_hit)
  );

  // Ops 5/6 reuse the full hit: clearing e on an already-invalid entry is a no-op.
  always_comb begin
    walk_clr     = 1'b0;
    walk_asid_eq = (walk_ent.asid == asid_q);
    case (op_q)
      INV_ALL0, INV_ALL1: walk_clr = 1'b1;
      INV_G1:             walk_clr = walk_ent.g;
      INV_G0:             walk_clr = !walk_ent.g;
      INV_ASID:           walk_clr = !walk_ent.g && walk_asid_eq;
      INV_ASID_VA:        walk_clr = !walk_ent.g && walk_hit;
      INV_GA_VA:          walk_clr = walk_hit;
      default:            walk_clr = 1'b0;
    endcase
    if (state_q != ST_WALK) walk_clr = 1'b0;
  end

  // NOTE: the array carries a reset because every entry must come out of reset invalid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) entries[i] <= '0;
    end else begin
      if (walk_clr) entries[cnt_q].e <= 1'b0;
      // Later assignment wins, so a write to the visited entry beats the clear.
      if (we) entries[w_index] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_entry <= '0;
    else         r_entry <= entries[r_index];
  end

endmodule
